div_by_mult_10: RTL and testbench

Sequential unsigned restoring divider. It recovers how many multiples of a step value make up an accumulated total: `quotient = dividend / divisor` and `remainder = dividend % divisor`. Each run takes one start pulse and one division. It sits downstream of the multiple-stepping counters, converting accumulated counts back into step numbers, for example for 7-segment display paths.

---
 rtl/div_by_mult_10_pkg.sv | 20 ++
 rtl/div_by_mult_10_if.sv | 33 +++
 rtl/div_by_mult_10_div_step.sv | 35 +++
 rtl/div_by_mult_10.sv | 115 +++++++++++
 tb/tb_div_by_mult_10.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/div_by_mult_10_pkg.sv
// Shared definitions for the div_by_mult_10 sequential divider.
//   - DEF_BIT_SZ : default operand/result width
//   - ST_*       : FSM state encodings (kept as plain 2-bit constants)
//   - cnt_width  : iteration counter width for a given operand width
package div_by_mult_10_pkg;

  localparam int DEF_BIT_SZ = 10;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // The counter must be able to hold the value BIT_SZ.
  function automatic int cnt_width(input int bit_sz);
    return $clog2(bit_sz + 1);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_BIT_SZ);

endpackage

// File: rtl/div_by_mult_10_if.sv
// Request/result bundle for div_by_mult_10.
//   master : drives start, dividend, divisor; observes results
//   slave  : the divider
//
// Handshake: start is a request that the divider takes on any clock edge
// where it is not busy (IDLE or DONE). The operands are captured on that
// same edge. busy is high while iterations run, and start is ignored then.
// done pulses for one cycle when quotient/remainder/div_zero become valid.
// The results then hold until the next accepted request completes.
// dbg_state mirrors the FSM state for observation only.
interface div_by_mult_10_if #(
  parameter int BIT_SZ = div_by_mult_10_pkg::DEF_BIT_SZ
);
  logic              start;
  logic [BIT_SZ-1:0] dividend;
  logic [BIT_SZ-1:0] divisor;
  logic              busy;
  logic              done;
  logic [BIT_SZ-1:0] quotient;
  logic [BIT_SZ-1:0] remainder;
  logic              div_zero;
  logic [1:0]        dbg_state;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_zero, dbg_state
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_zero, dbg_state
  );
endinterface

// File: rtl/div_by_mult_10_div_step.sv
// One combinational restoring-division step.
//   r_in    : partial remainder (BIT_SZ+1 bits, always < divisor here)
//   a_msb   : next dividend bit shifted into the remainder
//   divisor : denominator
//   r_out   : new partial remainder
//   q_bit   : quotient bit produced by this step
module div_step
  import div_by_mult_10_pkg::*;
#(
  parameter int BIT_SZ = DEF_BIT_SZ
) (
  input  logic [BIT_SZ:0]   r_in,
  input  logic              a_msb,
  input  logic [BIT_SZ-1:0] divisor,
  output logic [BIT_SZ:0]   r_out,
  output logic              q_bit
);

  logic [BIT_SZ:0] r_shift;
  logic [BIT_SZ:0] div_ext;

  // The incoming remainder is always below the divisor, so its top bit is
  // zero. Dropping that bit keeps the shifted value at BIT_SZ+1 bits.
  // The shifted value can reach 2*divisor-1.
  logic unused_r_msb;
  assign unused_r_msb = r_in[BIT_SZ];

  always_comb begin
    r_shift = {r_in[BIT_SZ-1:0], a_msb};
    div_ext = {1'b0, divisor};
    q_bit   = (r_shift >= div_ext);
    r_out   = q_bit ? (r_shift - div_ext) : r_shift;
  end

endmodule

// File: rtl/div_by_mult_10.sv
// Sequential unsigned restoring divider: quotient = dividend / divisor,
// remainder = dividend % divisor. It uses one restoring step per clock,
// BIT_SZ steps per division. Divide by zero finishes immediately. In that
// case quotient is all ones, remainder equals the dividend, and div_zero is set.
//   clock : rising-edge clock
//   reset : synchronous, active-high
//   bus   : request/result interface (slave side), see div_by_mult_10_if
module div_by_mult_10
  import div_by_mult_10_pkg::*;
#(
  parameter int BIT_SZ = DEF_BIT_SZ
) (
  input logic             clock,
  input logic             reset,
  div_by_mult_10_if.slave bus
);

  localparam int CNT_W = cnt_width(BIT_SZ);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIT_SZ - 1);

  logic [1:0]        state;
  logic [BIT_SZ-1:0] a_sh;      // dividend, shifted out MSB first
  logic [BIT_SZ-1:0] d_reg;     // latched divisor
  logic [BIT_SZ:0]   r_reg;     // partial remainder
  logic [BIT_SZ-1:0] q_sh;      // quotient bits collected so far
  logic [CNT_W-1:0]  cnt;

  logic              busy_q;
  logic              done_q;
  logic              dz_q;
  logic [BIT_SZ-1:0] quot_q;
  logic [BIT_SZ-1:0] rem_q;

  logic [BIT_SZ:0]   r_next;
  logic              q_bit;

  div_step #(.BIT_SZ(BIT_SZ)) u_step (
    .r_in    (r_reg),
    .a_msb   (a_sh[BIT_SZ-1]),
    .divisor (d_reg),
    .r_out   (r_next),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= ST_IDLE;
      a_sh   <= '0;
      d_reg  <= '0;
      r_reg  <= '0;
      q_sh   <= '0;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        // DONE accepts a new request exactly like IDLE, so a held start
        // gives back-to-back divisions.
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            a_sh  <= bus.dividend;
            d_reg <= bus.divisor;
            r_reg <= '0;
            q_sh  <= '0;
            cnt   <= '0;
            if (bus.divisor == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              dz_q   <= 1'b1;
              quot_q <= '1;
              rem_q  <= bus.dividend;
            end else begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh  <= {a_sh[BIT_SZ-2:0], 1'b0};
          r_reg <= r_next;
          q_sh  <= {q_sh[BIT_SZ-2:0], q_bit};
          cnt   <= cnt + CNT_W'(1);
          if (cnt == LAST_STEP) begin
            // Results are taken from the final step directly, so they
            // appear together with done.
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            dz_q   <= 1'b0;
            quot_q <= {q_sh[BIT_SZ-2:0], q_bit};
            rem_q  <= r_next[BIT_SZ-1:0];
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = dz_q;
  assign bus.quotient  = quot_q;
  assign bus.remainder = rem_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_div_by_mult_10.sv
// Directed bench for div_by_mult_10 (BIT_SZ = 10).
module tb_div_by_mult_10;
  localparam int W = 10;

  logic clock = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  div_by_mult_10_if #(.BIT_SZ(W)) bus();

  div_by_mult_10 #(.BIT_SZ(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // driver: issue one request and wait for done. lat counts the edges after the
  // accepting edge until done is seen (0 means done right after acceptance).
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic busy_e0, output logic busy_seen,
                        output logic [W-1:0] q, output logic [W-1:0] r, output logic dz);
    bus.start = 1'b1;
    bus.dividend = a;
    bus.divisor = b;
    tick();
    bus.start = 1'b0;
    busy_e0 = bus.busy;
    busy_seen = 1'b0;
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      busy_seen = busy_seen | bus.busy;
      tick();
      lat++;
    end
    q = bus.quotient;
    r = bus.remainder;
    dz = bus.div_zero;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.start = 1'b0;
    bus.dividend = '0;
    bus.divisor = '0;
    tick();
    tick();
    reset = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    vectors++; if (bus.quotient !== 10'd0) begin miscompares++; $display("FAIL reset_quotient: got %0d expected 0", bus.quotient); end
    vectors++; if (bus.remainder !== 10'd0) begin miscompares++; $display("FAIL reset_remainder: got %0d expected 0", bus.remainder); end
    vectors++; if (bus.div_zero !== 1'b0) begin miscompares++; $display("FAIL reset_div_zero: got %b expected 0", bus.div_zero); end
    vectors++; if (bus.dbg_state !== 2'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", bus.dbg_state); end
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [4] = '{10'd1000, 10'd1023, 10'd1023, 10'd5};
    logic [W-1:0] tb [4] = '{10'd10,   10'd7,    10'd1,    10'd9};
    logic [W-1:0] tq [4] = '{10'd100,  10'd146,  10'd1023, 10'd0};
    logic [W-1:0] tr [4] = '{10'd0,    10'd1,    10'd0,    10'd5};
    int lat;
    logic be0, bs, dz;
    logic [W-1:0] q, r;
    for (int i = 0; i < 4; i++) begin
      do_div(ta[i], tb[i], lat, be0, bs, q, r, dz);
      vectors++; if (be0 !== 1'b1) begin miscompares++; $display("FAIL basic_busy[%0d]: got %b expected 1", i, be0); end
      vectors++; if (lat !== 10) begin miscompares++; $display("FAIL basic_latency[%0d]: got %0d expected 10", i, lat); end
      vectors++; if (q !== tq[i]) begin miscompares++; $display("FAIL basic_quotient[%0d]: got %0d expected %0d", i, q, tq[i]); end
      vectors++; if (r !== tr[i]) begin miscompares++; $display("FAIL basic_remainder[%0d]: got %0d expected %0d", i, r, tr[i]); end
      vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL basic_div_zero[%0d]: got %b expected 0", i, dz); end
    end
    // done is a single-cycle pulse; results hold afterwards
    tick();
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %b expected 0", bus.done); end
    vectors++; if (bus.remainder !== 10'd5) begin miscompares++; $display("FAIL basic_hold: got %0d expected 5", bus.remainder); end
  endtask

  task automatic test_div_zero();
    int lat;
    logic be0, bs, dz;
    logic [W-1:0] q, r;
    do_div(10'd37, 10'd0, lat, be0, bs, q, r, dz);
    vectors++; if (lat !== 0) begin miscompares++; $display("FAIL dz_latency: got %0d expected 0", lat); end
    vectors++; if ((be0 | bs) !== 1'b0) begin miscompares++; $display("FAIL dz_busy: got %b expected 0", be0 | bs); end
    vectors++; if (q !== 10'd1023) begin miscompares++; $display("FAIL dz_quotient: got %0d expected 1023", q); end
    vectors++; if (r !== 10'd37) begin miscompares++; $display("FAIL dz_remainder: got %0d expected 37", r); end
    vectors++; if (dz !== 1'b1) begin miscompares++; $display("FAIL dz_flag: got %b expected 1", dz); end
    do_div(10'd40, 10'd8, lat, be0, bs, q, r, dz);
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL dz_next_latency: got %0d expected 10", lat); end
    vectors++; if (q !== 10'd5) begin miscompares++; $display("FAIL dz_next_quotient: got %0d expected 5", q); end
    vectors++; if (r !== 10'd0) begin miscompares++; $display("FAIL dz_next_remainder: got %0d expected 0", r); end
    vectors++; if (dz !== 1'b0) begin miscompares++; $display("FAIL dz_next_flag: got %b expected 0", dz); end
    tick();
  endtask

  task automatic test_ignore_start();
    int lat;
    bus.start = 1'b1;
    bus.dividend = 10'd600;
    bus.divisor = 10'd3;
    tick();                      // E0
    bus.start = 1'b0;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL ign_busy: got %b expected 1", bus.busy); end
    tick();                      // E1
    tick();                      // E2
    vectors++; if (bus.quotient !== 10'd5) begin miscompares++; $display("FAIL ign_hold_quotient: got %0d expected 5", bus.quotient); end
    tick();                      // E3
    bus.start = 1'b1;
    bus.dividend = 10'd99;
    bus.divisor = 10'd4;
    tick();                      // E4
    bus.start = 1'b0;
    lat = 4;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL ign_latency: got %0d expected 10", lat); end
    vectors++; if (bus.quotient !== 10'd200) begin miscompares++; $display("FAIL ign_quotient: got %0d expected 200", bus.quotient); end
    vectors++; if (bus.remainder !== 10'd0) begin miscompares++; $display("FAIL ign_remainder: got %0d expected 0", bus.remainder); end
    for (int i = 0; i < 4; i++) tick();
    vectors++; if ((bus.done | bus.busy) !== 1'b0) begin miscompares++; $display("FAIL ign_idle_after: got %b expected 0", bus.done | bus.busy); end
    vectors++; if (bus.quotient !== 10'd200) begin miscompares++; $display("FAIL ign_result_held: got %0d expected 200", bus.quotient); end
  endtask

  task automatic test_back_to_back();
    int lat;
    bus.start = 1'b1;
    bus.dividend = 10'd1000;
    bus.divisor = 10'd10;
    tick();                      // E0
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL b2b_first_latency: got %0d expected 10", lat); end
    vectors++; if (bus.quotient !== 10'd100) begin miscompares++; $display("FAIL b2b_first_quotient: got %0d expected 100", bus.quotient); end
    vectors++; if (bus.remainder !== 10'd0) begin miscompares++; $display("FAIL b2b_first_remainder: got %0d expected 0", bus.remainder); end
    bus.dividend = 10'd255;
    bus.divisor = 10'd16;
    tick();                      // E11: accepted while in DONE
    vectors++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin miscompares++; $display("FAIL b2b_accept: got busy=%b done=%b expected busy=1 done=0", bus.busy, bus.done); end
    vectors++; if (bus.quotient !== 10'd100) begin miscompares++; $display("FAIL b2b_hold: got %0d expected 100", bus.quotient); end
    lat = 0;
    while (bus.done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    bus.start = 1'b0;
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL b2b_second_latency: got %0d expected 10", lat); end
    vectors++; if (bus.quotient !== 10'd15) begin miscompares++; $display("FAIL b2b_second_quotient: got %0d expected 15", bus.quotient); end
    vectors++; if (bus.remainder !== 10'd15) begin miscompares++; $display("FAIL b2b_second_remainder: got %0d expected 15", bus.remainder); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int lat, done_cnt;
    logic be0, bs, dz;
    logic [W-1:0] q, r;
    bus.start = 1'b1;
    bus.dividend = 10'd1000;
    bus.divisor = 10'd7;
    tick();                      // E0
    bus.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();   // E1..E4
    reset = 1'b1;
    bus.start = 1'b1;
    tick();                      // E5
    reset = 1'b0;
    bus.start = 1'b0;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b expected 0", bus.done); end
    vectors++; if (bus.quotient !== 10'd0) begin miscompares++; $display("FAIL rst_quotient: got %0d expected 0", bus.quotient); end
    vectors++; if (bus.remainder !== 10'd0) begin miscompares++; $display("FAIL rst_remainder: got %0d expected 0", bus.remainder); end
    vectors++; if (bus.div_zero !== 1'b0) begin miscompares++; $display("FAIL rst_div_zero: got %b expected 0", bus.div_zero); end
    done_cnt = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.done === 1'b1) done_cnt++;
    end
    vectors++; if (done_cnt !== 0) begin miscompares++; $display("FAIL rst_no_done: got %0d pulses expected 0", done_cnt); end
    do_div(10'd81, 10'd9, lat, be0, bs, q, r, dz);
    vectors++; if (lat !== 10) begin miscompares++; $display("FAIL rst_next_latency: got %0d expected 10", lat); end
    vectors++; if (q !== 10'd9) begin miscompares++; $display("FAIL rst_next_quotient: got %0d expected 9", q); end
    vectors++; if (r !== 10'd0) begin miscompares++; $display("FAIL rst_next_remainder: got %0d expected 0", r); end
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
